// File: rtl/spi_arb_pkg.sv
// Shared types and sizing helpers for the SPI bus arbiter.
// Optional idle-grant watchdog is enabled with SPI_ARB_TIMEOUT_EN.
package spi_arb_pkg;

   localparam int SPI_BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_LOAD,
      ST_WAIT,
      ST_HOLD
   } arb_state_e;

   function automatic int spi_arb_cnt_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

   function automatic int spi_arb_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i,
// wrapping, as a one-hot grant plus its index.
module spi_rr_pick
   import spi_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = spi_arb_idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [IW:0]   sum;
   logic [IW-1:0] pos;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      sum   = '0;
      pos   = '0;
      for (int i = 0; i < N; i++) begin
         // ptr < N and i < N, so one subtraction wraps the sum
         sum = {1'b0, ptr_i} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         pos = sum[IW-1:0];
         if (!any_o && req_i[pos]) begin
            any_o      = 1'b1;
            gnt_o[pos] = 1'b1;
            idx_o      = pos;
         end
      end
   end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Per-transaction round-robin arbiter sharing one SPI byte engine.
// Define SPI_ARB_TIMEOUT_EN to enable the idle-grant watchdog.
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*SPI_BYTE_W-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   output logic [SPI_BYTE_W-1:0]         rsp_data_o,
   output logic                          eng_start_o,
   output logic [SPI_BYTE_W-1:0]         eng_tx_o,
   input  logic                          eng_busy_i,
   input  logic                          eng_done_i,
   input  logic [SPI_BYTE_W-1:0]         eng_rx_i,
   output logic [NUM_REQ-1:0]            spi_cs_o,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          abort_o
);

   localparam int IW = spi_arb_idx_w(NUM_REQ);

   if (NUM_REQ < 1 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("spi_bus_arbiter: parameter out of range");
   end

   arb_state_e              state_q;
   logic [IW-1:0]           owner_q;
   logic [IW-1:0]           rr_ptr_q;
   logic [IW-1:0]           rr_ptr_d;
   logic [NUM_REQ-1:0]      grant_q;
   logic [NUM_REQ-1:0]      cs_q;
   logic                    last_q;
   logic [NUM_REQ-1:0]      rsp_valid_q;
   logic [SPI_BYTE_W-1:0]   rsp_data_q;

   logic [NUM_REQ-1:0]      pick_gnt;
   logic [IW-1:0]           pick_idx;
   logic                    pick_any;
   logic                    own_valid;
   logic                    own_last;
   logic [SPI_BYTE_W-1:0]   own_data;
   logic                    accept;
   logic                    timeout_d;

   spi_rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req_i (req_valid_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign own_valid = |(req_valid_i & grant_q);
   assign own_last  = |(req_last_i & grant_q);

   always_comb begin
      own_data = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (grant_q[r]) begin
            own_data = own_data | req_data_i[r*SPI_BYTE_W +: SPI_BYTE_W];
         end
      end
   end

   assign accept      = (state_q == ST_LOAD) && own_valid && !eng_busy_i;
   assign req_ready_o = accept ? grant_q : '0;
   assign eng_start_o = accept;
   assign eng_tx_o    = accept ? own_data : '0;

   assign rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CNT_W = spi_arb_cnt_w(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] idle_cnt_q;
   logic             abort_q;

   // Fires on the cycle that completes TIMEOUT_CYCLES idle LOAD cycles
   assign timeout_d = (state_q == ST_LOAD) && !own_valid &&
                      (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         idle_cnt_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         abort_q <= timeout_d;
         if (state_q != ST_LOAD || own_valid || timeout_d) begin
            idle_cnt_q <= '0;
         end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
         end
      end
   end

   assign abort_o = abort_q;
`else
   assign timeout_d = 1'b0;
   assign abort_o   = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         cs_q        <= '1;
         last_q      <= 1'b0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= '0;
         unique case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  owner_q <= pick_idx;
                  grant_q <= pick_gnt;
                  cs_q    <= ~pick_gnt;
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: state_q <= ST_LOAD;
            ST_LOAD: begin
               if (accept) begin
                  last_q  <= own_last;
                  state_q <= ST_WAIT;
               end else if (timeout_d) begin
                  state_q <= ST_HOLD;
               end
            end
            ST_WAIT: begin
               if (eng_done_i) begin
                  rsp_data_q  <= eng_rx_i;
                  rsp_valid_q <= grant_q;
                  state_q     <= last_q ? ST_HOLD : ST_LOAD;
               end
            end
            ST_HOLD: begin
               cs_q     <= '1;
               grant_q  <= '0;
               rr_ptr_q <= rr_ptr_d;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign spi_cs_o    = cs_q;
   assign grant_o     = grant_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: cycle table plus corner sequences.
// The watchdog sequence runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_last = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [7:0]  rsp_data;
   logic        eng_start;
   logic [7:0]  eng_tx;
   logic        eng_busy;
   logic        eng_done;
   logic [7:0]  eng_rx;
   logic [3:0]  spi_cs;
   logic [3:0]  grant;
   logic        abort;

   logic        auto_eng = 1'b0;
   logic        busy_force = 1'b0;
   logic        t_busy = 1'b0;
   logic        t_done = 1'b0;
   logic [7:0]  t_rx = '0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [7:0]  m_rx = '0;
   logic [7:0]  m_sh = '0;
   int          m_cnt = 0;

   assign eng_busy = auto_eng ? (m_busy | busy_force) : t_busy;
   assign eng_done = auto_eng ? m_done : t_done;
   assign eng_rx   = auto_eng ? m_rx : t_rx;

   always #5 clk = ~clk;

   spi_bus_arbiter #(
      .NUM_REQ        (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .sys_clk     (clk),
      .sys_rst_n   (rst_n),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_last_i  (req_last),
      .req_ready_o (req_ready),
      .rsp_valid_o (rsp_valid),
      .rsp_data_o  (rsp_data),
      .eng_start_o (eng_start),
      .eng_tx_o    (eng_tx),
      .eng_busy_i  (eng_busy),
      .eng_done_i  (eng_done),
      .eng_rx_i    (eng_rx),
      .spi_cs_o    (spi_cs),
      .grant_o     (grant),
      .abort_o     (abort)
   );

   // Loopback engine: busy 4 cycles, then done with rx = tx
   always @(posedge clk) begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_done <= 1'b1;
            m_rx   <= m_sh;
            m_busy <= 1'b0;
         end
      end else if (auto_eng && eng_start) begin
         m_busy <= 1'b1;
         m_cnt  <= 4;
         m_sh   <= eng_tx;
      end
   end

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      logic        b;
      logic        dn;
      logic [7:0]  rx;
      logic [3:0]  cs;
      logic [3:0]  g;
      logic [3:0]  rdy;
      logic        st;
      logic [7:0]  tx;
      logic [3:0]  rv;
      logic [7:0]  rd;
   } vec_t;

   vec_t tbl[18];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cyc = 0;
   int rise_cyc = 0;
   int abort_cyc = 0;
   logic [3:0] prev_g = '0;
   logic [3:0] prev_cs = 4'hF;
   logic [3:0] rdy_s = '0;
   int glog[$];
   logic [11:0] rlog[$];

   logic       drv_en = 1'b0;
   logic [7:0] mem_d[4][8];
   logic       mem_l[4][8];
   int         qcnt[4];
   int         qhd[4];

   function automatic vec_t mk(
      logic [3:0] v, logic [3:0] l, logic [31:0] d,
      logic b, logic dn, logic [7:0] rx,
      logic [3:0] cs, logic [3:0] g, logic [3:0] rdy,
      logic st, logic [7:0] tx, logic [3:0] rv, logic [7:0] rd);
      vec_t x;
      x.v = v; x.l = l; x.d = d; x.b = b; x.dn = dn; x.rx = rx;
      x.cs = cs; x.g = g; x.rdy = rdy; x.st = st; x.tx = tx;
      x.rv = rv; x.rd = rd;
      return x;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic observe();
      logic bad;
      cyc++;
      bad = (spi_cs !== ~grant) || ($countones(grant) > 1) ||
            (grant != 0 && prev_g != 0 && grant != prev_g);
`ifndef SPI_ARB_TIMEOUT_EN
      bad = bad || (abort !== 1'b0);
`endif
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL bus_rules cyc=%0d cs=%b grant=%b prev=%b abort=%b",
                  cyc, spi_cs, grant, prev_g, abort);
      end
      if (grant != 0 && prev_g == 0) begin
         for (int i = 0; i < 4; i++) if (grant[i]) glog.push_back(i);
      end
      if (rsp_valid != 0) rlog.push_back({rsp_valid, rsp_data});
      if (eng_done) done_cyc = cyc;
      if (spi_cs == 4'hF && prev_cs != 4'hF) rise_cyc = cyc;
      if (abort) abort_cyc = cyc;
      prev_g  = grant;
      prev_cs = spi_cs;
      rdy_s   = req_ready;
   endtask

   task automatic q_clear();
      for (int r = 0; r < 4; r++) begin
         qcnt[r] = 0;
         qhd[r]  = 0;
      end
   endtask

   task automatic q_push(int r, logic [7:0] d, logic l);
      mem_d[r][qcnt[r]] = d;
      mem_l[r][qcnt[r]] = l;
      qcnt[r]++;
   endtask

   function automatic logic pending();
      logic p = 1'b0;
      for (int r = 0; r < 4; r++) if (qhd[r] < qcnt[r]) p = 1'b1;
      return p;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (drv_en) begin
         for (int r = 0; r < 4; r++) begin
            if (rdy_s[r]) qhd[r]++;
            if (qhd[r] < qcnt[r]) begin
               req_valid[r]       = 1'b1;
               req_last[r]        = mem_l[r][qhd[r]];
               req_data[8*r +: 8] = mem_d[r][qhd[r]];
            end else begin
               req_valid[r]       = 1'b0;
               req_last[r]        = 1'b0;
               req_data[8*r +: 8] = 8'h00;
            end
         end
      end
      @(negedge clk);
      observe();
   endtask

   task automatic run_until_idle(string nm, int bound);
      int n = 0;
      step();
      while ((pending() || grant != 0 || eng_busy) && n < bound) begin
         step();
         n++;
      end
      if (n >= bound) chk({nm, "_bound"}, 64'(n), 64'(bound - 1));
   endtask

   task automatic do_reset();
      drv_en     = 1'b0;
      busy_force = 1'b0;
      req_valid  = '0;
      req_last   = '0;
      req_data   = '0;
      t_busy     = 1'b0;
      t_done     = 1'b0;
      t_rx       = '0;
      rst_n      = 1'b0;
      q_clear();
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      observe();
      glog.delete();
      rlog.delete();
      rdy_s = '0;
   endtask

   function automatic logic [31:0] pack_g(int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v = (v << 4) | 32'(glog[i]);
      return v;
   endfunction

   initial begin
      int t0;
      int rc;
      int bad;
      int n;

      //            v     l     data          b  dn rx     cs    g     rdy   st tx     rv    rd
      tbl[0]  = mk(4'h2, 4'h0, 32'h0000A500, 0, 0, 8'h00, 4'hF, 4'h0, 4'h0, 0, 8'h00, 4'h0, 8'h00);
      tbl[1]  = mk(4'h2, 4'h0, 32'h0000A500, 0, 0, 8'h00, 4'hD, 4'h2, 4'h0, 0, 8'h00, 4'h0, 8'h00);
      tbl[2]  = mk(4'h2, 4'h0, 32'h0000A500, 0, 0, 8'h00, 4'hD, 4'h2, 4'h2, 1, 8'hA5, 4'h0, 8'h00);
      tbl[3]  = mk(4'h2, 4'h2, 32'h00003C00, 1, 0, 8'h00, 4'hD, 4'h2, 4'h0, 0, 8'h00, 4'h0, 8'h00);
      tbl[4]  = mk(4'h2, 4'h2, 32'h00003C00, 0, 1, 8'h5A, 4'hD, 4'h2, 4'h0, 0, 8'h00, 4'h0, 8'h00);
      tbl[5]  = mk(4'h2, 4'h2, 32'h00003C00, 0, 0, 8'h00, 4'hD, 4'h2, 4'h2, 1, 8'h3C, 4'h2, 8'h5A);
      tbl[6]  = mk(4'h0, 4'h0, 32'h00000000, 0, 1, 8'hC3, 4'hD, 4'h2, 4'h0, 0, 8'h00, 4'h0, 8'h5A);
      tbl[7]  = mk(4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'hD, 4'h2, 4'h0, 0, 8'h00, 4'h2, 8'hC3);
      tbl[8]  = mk(4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'hF, 4'h0, 4'h0, 0, 8'h00, 4'h0, 8'hC3);
      tbl[9]  = mk(4'h0, 4'h0, 32'h00000000, 0, 1, 8'hFF, 4'hF, 4'h0, 4'h0, 0, 8'h00, 4'h0, 8'hC3);
      tbl[10] = mk(4'h9, 4'h9, 32'h11000022, 0, 0, 8'h00, 4'hF, 4'h0, 4'h0, 0, 8'h00, 4'h0, 8'hC3);
      tbl[11] = mk(4'h9, 4'h9, 32'h11000022, 0, 0, 8'h00, 4'h7, 4'h8, 4'h0, 0, 8'h00, 4'h0, 8'hC3);
      tbl[12] = mk(4'h9, 4'h9, 32'h11000022, 0, 0, 8'h00, 4'h7, 4'h8, 4'h8, 1, 8'h11, 4'h0, 8'hC3);
      tbl[13] = mk(4'h1, 4'h1, 32'h00000022, 0, 1, 8'h77, 4'h7, 4'h8, 4'h0, 0, 8'h00, 4'h0, 8'hC3);
      tbl[14] = mk(4'h1, 4'h1, 32'h00000022, 0, 0, 8'h00, 4'h7, 4'h8, 4'h0, 0, 8'h00, 4'h8, 8'h77);
      tbl[15] = mk(4'h1, 4'h1, 32'h00000022, 0, 0, 8'h00, 4'hF, 4'h0, 4'h0, 0, 8'h00, 4'h0, 8'h77);
      tbl[16] = mk(4'h1, 4'h1, 32'h00000022, 0, 0, 8'h00, 4'hE, 4'h1, 4'h0, 0, 8'h00, 4'h0, 8'h77);
      tbl[17] = mk(4'h1, 4'h1, 32'h00000022, 1, 0, 8'h00, 4'hE, 4'h1, 4'h0, 0, 8'h00, 4'h0, 8'h77);

      // Reset state
      do_reset();
      chk("rst_cs", 64'(spi_cs), 64'hF);
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_start", 64'(eng_start), 64'h0);
      chk("rst_tx", 64'(eng_tx), 64'h0);
      chk("rst_rspv", 64'(rsp_valid), 64'h0);
      chk("rst_rspd", 64'(rsp_data), 64'h0);
      chk("rst_abort", 64'(abort), 64'h0);

      // Cycle table with a hand-driven engine
      auto_eng = 1'b0;
      for (int k = 0; k < 18; k++) begin
         @(posedge clk);
         #1;
         req_valid = tbl[k].v;
         req_last  = tbl[k].l;
         req_data  = tbl[k].d;
         t_busy    = tbl[k].b;
         t_done    = tbl[k].dn;
         t_rx      = tbl[k].rx;
         @(negedge clk);
         observe();
         chk($sformatf("vec%0d", k),
             {31'd0, spi_cs, grant, req_ready, eng_start, eng_tx,
              rsp_valid, rsp_data},
             {31'd0, tbl[k].cs, tbl[k].g, tbl[k].rdy, tbl[k].st,
              tbl[k].tx, tbl[k].rv, tbl[k].rd});
      end

      // Single two-byte transaction on r1 with loopback engine
      auto_eng = 1'b1;
      do_reset();
      q_push(1, 8'hA5, 1'b0);
      q_push(1, 8'h3C, 1'b1);
      drv_en = 1'b1;
      step();
      t0 = cyc;
      chk("single_cs_t", 64'(spi_cs), 64'hF);
      step();
      chk("single_cs_t1", 64'(spi_cs), 64'hD);
      step();
      chk("single_start_t2", {cyc - t0, eng_start, req_ready, eng_tx},
          {32'd2, 1'b1, 4'h2, 8'hA5});
      run_until_idle("single", 60);
      chk("single_rsp_n", 64'(rlog.size()), 64'd2);
      if (rlog.size() == 2) begin
         chk("single_rsp", {rlog[0], rlog[1]}, {12'h2A5, 12'h23C});
      end
      chk("single_cs_rise", 64'(rise_cyc - done_cyc), 64'd2);

      // Contention: r0, r2, r3 pending from reset
      do_reset();
      q_push(0, 8'h10, 1'b1);
      q_push(2, 8'h12, 1'b1);
      q_push(3, 8'h13, 1'b1);
      drv_en = 1'b1;
      run_until_idle("cont", 100);
      chk("cont_n", 64'(glog.size()), 64'd3);
      if (glog.size() == 3) chk("cont_order", 64'(pack_g(3)), 64'h023);
      if (rlog.size() == 3) begin
         chk("cont_rsp", {rlog[0], rlog[1], rlog[2]},
             {12'h110, 12'h412, 12'h813});
      end else begin
         chk("cont_rsp_n", 64'(rlog.size()), 64'd3);
      end

      // Fairness under continuous demand
      do_reset();
      for (int r = 0; r < 4; r++) begin
         q_push(r, 8'(16 * r), 1'b1);
         q_push(r, 8'(16 * r + 1), 1'b1);
      end
      drv_en = 1'b1;
      run_until_idle("fair", 200);
      chk("fair_n", 64'(glog.size()), 64'd8);
      if (glog.size() == 8) chk("fair_order", 64'(pack_g(8)), 64'h01230123);

      // Engine backpressure while r0 sits in LOAD
      do_reset();
      busy_force = 1'b1;
      q_push(0, 8'h5E, 1'b1);
      drv_en = 1'b1;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (eng_start || req_ready != 0) bad++;
      end
      chk("bp_stall", 64'(bad), 64'd0);
      chk("bp_grant", 64'(grant), 64'h1);
      @(posedge clk);
      #1 busy_force = 1'b0;
      @(negedge clk);
      observe();
      chk("bp_release", {eng_start, req_ready, eng_tx}, {1'b1, 4'h1, 8'h5E});
      run_until_idle("bp", 60);
      chk("bp_rsp_n", 64'(rlog.size()), 64'd1);
      if (rlog.size() == 1) chk("bp_rsp", 64'(rlog[0]), 64'h15E);

      // Reset during WAIT: advance rr_ptr first so a stale pointer shows
      do_reset();
      q_push(2, 8'h22, 1'b1);
      drv_en = 1'b1;
      run_until_idle("pre", 60);
      q_clear();
      q_push(1, 8'h44, 1'b1);
      n = 0;
      while (!eng_start && n < 12) begin
         step();
         n++;
      end
      chk("mid_started", 64'(eng_start), 64'h1);
      @(posedge clk);
      #1;
      drv_en    = 1'b0;
      req_valid = '0;
      req_last  = '0;
      rst_n     = 1'b0;
      @(negedge clk);
      observe();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      observe();
      rc = cyc;
      chk("mid_rst_out", {spi_cs, grant, rsp_valid, req_ready, eng_start},
          {4'hF, 4'h0, 4'h0, 4'h0, 1'b0});
      rlog.delete();
      repeat (8) step();
      chk("mid_done_seen", 64'(done_cyc > rc), 64'h1);
      chk("mid_no_rsp", 64'(rlog.size()), 64'd0);
      glog.delete();
      q_clear();
      q_push(1, 8'h11, 1'b1);
      q_push(3, 8'h33, 1'b1);
      drv_en = 1'b1;
      run_until_idle("post", 100);
      chk("post_n", 64'(glog.size()), 64'd2);
      if (glog.size() == 2) chk("post_order", 64'(pack_g(2)), 64'h13);

`ifdef SPI_ARB_TIMEOUT_EN
      // Watchdog: r2 stalls after a non-last byte, r3 waits
      do_reset();
      q_push(2, 8'h2A, 1'b0);
      q_push(3, 8'h3B, 1'b1);
      drv_en = 1'b1;
      abort_cyc = 0;
      n = 0;
      while (!abort && n < 60) begin
         step();
         n++;
      end
      chk("to_abort", 64'(abort), 64'h1);
      chk("to_abort_cyc", 64'(abort_cyc - done_cyc), 64'd17);
      step();
      chk("to_cs_rise", 64'(rise_cyc - abort_cyc), 64'd1);
      run_until_idle("to", 100);
      chk("to_n", 64'(glog.size()), 64'd2);
      if (glog.size() == 2) chk("to_order", 64'(pack_g(2)), 64'h23);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares one byte-wide SPI shift engine and its bus among `NUM_REQ` requesters. Each grant covers a whole multi-byte transaction under that requester's own active-low chip select. Grants are issued round-robin per transaction, never per byte. Sits between on-chip SPI clients and the SPI master engine (RTL engine or DPI-backed master).

## Interface
- `NUM_REQ`, 4: number of requesters and chip selects, 1..16.
- `TIMEOUT_CYCLES`, 1024: idle-grant watchdog limit; used only with `SPI_ARB_TIMEOUT_EN`.

Ports:
- `sys_clk`  in  1  single clock; all logic on posedge.
- `sys_rst_n`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  NUM_REQ  requester r has a TX byte on its data slice.
- `req_data_i`  in  NUM_REQ*8  TX byte of requester r in bits [8r+7:8r].
- `req_last_i`  in  NUM_REQ  byte is the last of r's transaction.
- `req_ready_o`  out  NUM_REQ  byte of r accepted this cycle.
- `rsp_valid_o`  out  NUM_REQ  one-cycle pulse: RX byte for r is on `rsp_data_o`.
- `rsp_data_o`  out  8  RX byte, shared by all requesters.
- `eng_start_o`  out  1  start one byte shift.
- `eng_tx_o`  out  8  byte to shift out.
- `eng_busy_i`  in  1  engine mid-byte.
- `eng_done_i`  in  1  one-cycle pulse: byte finished, `eng_rx_i` valid.
- `eng_rx_i`  in  8  received byte.
- `spi_cs_o`  out  NUM_REQ  per-slave chip select, active-low.
- `grant_o`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `abort_o`  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
FSM states and transitions:
- IDLE: all CS high, `grant_o`=0. If any `req_valid_i` is set, pick the first set bit at or after `rr_ptr`, wrapping. Latch it as owner g and go to SETUP.
- SETUP: `spi_cs_o[g]`=0. Lasts 1 cycle for CS-to-SCLK setup, then go to LOAD.
- LOAD: accept a byte when `req_valid_i[g] && !eng_busy_i`.
  - `req_ready_o[g]` and `eng_start_o` are asserted combinationally in that same cycle.
  - `eng_tx_o` = g's byte.
  - Latch `req_last_i[g]` and go to WAIT.
  - `eng_tx_o` = 0 outside an accept cycle.
- WAIT: on `eng_done_i`, register `eng_rx_i` into `rsp_data_o` and pulse `rsp_valid_o[g]` the next cycle. Go to HOLD if the latched last flag is set, otherwise go to LOAD.
- HOLD: CS stays low 1 cycle (hold time). Then `rr_ptr` = (g+1) mod NUM_REQ and go to IDLE.

Rules:
- Only the owner gets `req_ready_o`. Other requesters keep `req_valid_i` high and wait; dropping valid before it is accepted is allowed.
- `eng_done_i` is ignored outside WAIT.
- Reset values:
  - State IDLE; `rr_ptr`=0.
  - `spi_cs_o` all 1.
  - All other outputs 0.
- Reset mid-transaction: CS deasserts in the cycle after reset is sampled. A pending `eng_done_i` is dropped. No `rsp_valid_o` is issued.
- `NUM_REQ`=1: arbitration is degenerate; the FSM is unchanged.

## Timing
- `req_valid_i` sampled in IDLE at cycle t:
  - `spi_cs_o[g]` falls at t+1.
  - Earliest `eng_start_o` at t+2.
- `eng_done_i` at cycle d gives `rsp_valid_o[g]` at d+1.
  - Next `eng_start_o` is possible at d+1 (non-last byte).
  - If last: CS rises at d+2.
- Minimum CS-high gap between transactions is 1 cycle (IDLE).
- Back-to-back requesters alternate strictly under continuous demand.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter in LOAD counts consecutive cycles with `req_valid_i[g]`=0. It clears on entering LOAD and on every accept.
  - When the count reaches `TIMEOUT_CYCLES`: pulse `abort_o` and go to HOLD, which releases CS and advances `rr_ptr`.
- Not defined: LOAD waits indefinitely; `abort_o` is tied 0; no counter logic.

## Structure
- Package `spi_arb_pkg`:
  - State enum.
  - `SPI_BYTE_W`=8.
  - Timeout counter width derived via `$clog2(TIMEOUT_CYCLES+1)`.
- Sub-module `spi_rr_pick`: combinational round-robin picker from request vector and pointer, producing a one-hot grant and its index. The FSM, CS registers and data muxes stay in `spi_bus_arbiter`.

## Test plan
- Single transaction: r1 sends 0xA5, 0x3C with last on byte 2; engine loops back tx to rx after 4 cycles.
  - `spi_cs_o`=4'b1101 from t+1.
  - `eng_start_o` at t+2.
  - Two `rsp_valid_o[1]` pulses carrying 0xA5 and 0x3C.
  - CS all high 2 cycles after the second `eng_done_i`.
- Contention: r0, r2, r3 each hold a 1-byte transaction from reset.
  - Grant order 0, 2, 3.
  - Every CS-high gap ≥1 cycle.
  - `grant_o` never has two bits set.
- Fairness: all four requesters continuously valid for 8 transactions → grant order 0,1,2,3,0,1,2,3.
- Engine backpressure: `eng_busy_i` held high 10 cycles while r0 is valid in LOAD → no `eng_start_o` or `req_ready_o` until busy falls, then both in the same cycle.
- Reset mid-byte: assert `sys_rst_n`=0 during WAIT.
  - Next cycle CS all 1, outputs 0.
  - A following `eng_done_i` produces no `rsp_valid_o`.
  - Next grant starts from r0.
- With `SPI_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16: r2 sends a non-last byte then drops valid.
  - `abort_o` pulses 16 cycles after LOAD entry.
  - `spi_cs_o[2]` rises 1 cycle later.
  - Waiting r3 is granted next.
